// File: rtl/des_counter_pkg.sv
// Shared definitions for the DES key-search message counters.
//   state_t       : run-control FSM encoding (IDLE/RUN/DONE)
//   DEFAULT_LANES : lane count shared with the top-level array of DES cores
package des_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_LANES = 4;

endpackage

// File: rtl/multi_lane_message_counter.sv
// Multi-lane message counter. Each beat presents LANES consecutive values
// (base+0 .. base+LANES-1) and then advances base by LANES. A run can be
// bounded to num_beats beats or left unbounded (num_beats == 0). Runs can be
// stopped early with abort.
//
// Ports:
//   clk, rst      : clock; synchronous active-high reset
//   start         : begin a run (only looked at in IDLE)
//   abort         : end a run without a done pulse (only looked at in RUN)
//   message_seed  : first counter value, captured on start
//   num_beats     : beats to emit, captured on start; 0 = unbounded
//   out_ready     : consumer takes the current beat
//   counters      : lane i at counters[i*WIDTH +: WIDTH]
//   valid, last   : beat valid / final beat of a bounded run
//   done          : one-cycle pulse after the final beat is taken
//   busy          : high in RUN and DONE
module multi_lane_message_counter
    import des_counter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LANES = DEFAULT_LANES,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WIDTH-1:0]         message_seed,
    input  logic [CNT_W-1:0]         num_beats,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   counters,
    output logic                     valid,
    output logic                     last,
    output logic                     done,
    output logic                     busy
);

    // Truncation is intended: LANES == 2^WIDTH steps by 0 modulo 2^WIDTH.
    localparam logic [WIDTH-1:0] STEP = WIDTH'(LANES);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   base_q;
    logic [CNT_W-1:0]   beats_left_q;
    logic               bounded_q;
    logic               accept;

    // All outputs decode from registered state only.
    assign valid  = (state_q == RUN);
    assign busy   = (state_q == RUN) || (state_q == DONE);
    assign done   = (state_q == DONE);
    // Gated with RUN: an abort can leave beats_left at 1 with bounded set.
    assign last   = valid && bounded_q && (beats_left_q == CNT_W'(1));
    assign accept = valid && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign counters[i*WIDTH +: WIDTH] = base_q + WIDTH'(i);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                // abort wins over the final-beat transition
                if (abort)               state_d = IDLE;
                else if (accept && last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            beats_left_q <= '0;
            bounded_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                base_q       <= message_seed;
                beats_left_q <= num_beats;
                bounded_q    <= (num_beats != '0);
            end else if (accept) begin
                // a beat accepted alongside abort still counts as delivered
                base_q <= base_q + STEP;
                if (bounded_q) beats_left_q <= beats_left_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multi_lane_message_counter.sv
module tb_multi_lane_message_counter;

    localparam int W  = 64;
    localparam int L  = 4;
    localparam int CW = 32;

    logic           clk = 1'b0;
    logic           rst, start, abort, out_ready;
    logic [W-1:0]   seed;
    logic [CW-1:0]  nb;
    logic [L*W-1:0] counters;
    logic           valid, last, done, busy;

    logic           start1, abort1, ready1;
    logic [W-1:0]   seed1;
    logic [CW-1:0]  nb1;
    logic [W-1:0]   counters1;
    logic           valid1, last1, done1, busy1;

    always #5 clk = ~clk;

    multi_lane_message_counter #(.WIDTH(W), .LANES(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .message_seed(seed), .num_beats(nb), .out_ready(out_ready),
        .counters(counters), .valid(valid), .last(last), .done(done), .busy(busy)
    );

    multi_lane_message_counter #(.WIDTH(W), .LANES(1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .message_seed(seed1), .num_beats(nb1), .out_ready(ready1),
        .counters(counters1), .valid(valid1), .last(last1), .done(done1), .busy(busy1)
    );

    typedef struct {
        logic [L*W-1:0] c;
        logic           l;
    } beat_t;

    typedef struct {
        logic [W-1:0]  seed;
        logic [CW-1:0] nb;
        int            stall_beat;
        int            stall_n;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[4];
    int    n_chk = 0;
    int    n_pass = 0;

    task automatic chk(input string nm, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat b of a run from seed s: lane i = s + b*L + i (mod 2^W).
    function automatic logic [L*W-1:0] beat_of(input logic [W-1:0] s, input int b);
        logic [L*W-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = s + W'(b*L + i);
        return r;
    endfunction

    task automatic run_bounded(input vec_t v);
        int  beats   = 0;
        int  stalled = 0;
        bit  fin     = 0;
        seed = v.seed; nb = v.nb; out_ready = 1'b1; start = 1'b1;
        for (int b = 0; b < int'(v.nb); b++) sb.push_back('{beat_of(v.seed, b), b == int'(v.nb) - 1});
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            out_ready = !(beats == v.stall_beat && stalled < v.stall_n);
            chk("run_valid", valid, 1);
            if (sb.size() > 0) begin
                chk("run_counters", counters, sb[0].c);
                chk("run_last", last, sb[0].l);
                if (out_ready) begin
                    fin = sb[0].l;
                    void'(sb.pop_front());
                    beats++;
                end else stalled++;
            end
            tick();
        end
        if (!fin) begin
            n_chk++;
            $display("FAIL run_timeout: beats seen %0d required %0d", beats, v.nb);
        end
        // DONE cycle; a start here must be ignored
        chk("done_pulse", done, 1);
        chk("done_valid", valid, 0);
        chk("done_busy", busy, 1);
        start = 1'b1; seed = ~v.seed;
        tick();
        start = 1'b0;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        tick();
        chk("start_in_done_ignored", valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; out_ready = 0; seed = '0; nb = '0;
        start1 = 0; abort1 = 0; ready1 = 1; seed1 = '0; nb1 = '0;
        vecs[0] = '{64'h10, 32'd3, -1, 0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFE, 32'd2, -1, 0};
        vecs[2] = '{64'h1234_0000, 32'd2, 0, 3};
        vecs[3] = '{64'h7, 32'd1, -1, 0};
        tick(); tick();

        // reset state
        chk("rst_valid", valid, 0);
        chk("rst_last", last, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_counters", counters, beat_of('0, 0));
        rst = 1'b0;
        tick();

        foreach (vecs[k]) run_bounded(vecs[k]);

        // unbounded, ignored start in RUN, abort together with accept on beat 10
        seed = 64'h1000; nb = '0; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 10; b++) begin
            chk("unb_valid", valid, 1);
            chk("unb_counters", counters, beat_of(64'h1000, b));
            chk("unb_last", last, 0);
            if (b == 2) begin start = 1'b1; seed = 64'hDEAD; end
            else start = 1'b0;
            if (b == 9) abort = 1'b1;
            tick();
        end
        abort = 1'b0; start = 1'b0;
        chk("abort_valid", valid, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        tick();
        chk("abort_no_done", done, 0);

        // abort beats the last-beat transition to DONE
        seed = 64'h40; nb = 32'd1; start = 1'b1;
        tick();
        start = 1'b0; abort = 1'b1;
        chk("abort_last_flag", last, 1);
        tick();
        abort = 1'b0;
        chk("abort_last_done", done, 0);
        chk("abort_last_valid", valid, 0);

        // reset during beat 2
        seed = 64'h100; nb = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rr_beat1", counters, beat_of(64'h100, 0));
        tick();
        chk("rr_beat2", counters, beat_of(64'h100, 1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_valid", valid, 0);
        chk("rr_busy", busy, 0);
        chk("rr_last", last, 0);
        chk("rr_done", done, 0);
        chk("rr_counters", counters, beat_of('0, 0));
        tick();
        chk("rr_no_done", done, 0);
        run_bounded('{64'hABC, 32'd2, -1, 0});

        // single lane: 5,6,7,8 then done
        seed1 = 64'd5; nb1 = 32'd4; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("l1_valid", valid1, 1);
            chk("l1_counter", counters1, 64'd5 + 64'(b));
            chk("l1_last", last1, b == 3);
            tick();
        end
        chk("l1_done", done1, 1);
        chk("l1_done_valid", valid1, 0);
        tick();
        chk("l1_idle", busy1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
